// File: rtl/clock_pkg.sv
// Shared definitions for the clock-face time controller: mode encoding,
// field moduli and the field width.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned MIN_SEC_MOD   = 60;
  localparam int unsigned TIME_W        = 6;

  // RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN relies on the 2-bit wrap.
  function automatic mode_e next_mode(mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button/vsync inputs and display outputs of the time controller.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic              btn_dec;
  logic              vsync;
  logic [TIME_W-1:0] hour;
  logic [TIME_W-1:0] minute;
  logic [TIME_W-1:0] second;
  logic [1:0]        mode;
  logic              blink;
  logic              sec_tick;

  modport master (
    output btn_mode, btn_inc, btn_dec, vsync,
    input  hour, minute, second, mode, blink, sec_tick
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, vsync,
    output hour, minute, second, mode, blink, sec_tick
  );

endinterface

// File: rtl/mod_counter.sv
// Wrapping up/down counter modulo MODULUS; carry flags an increment that wraps.
module mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              inc,
  input  logic              dec,
  output logic [TIME_W-1:0] value,
  output logic              carry
);

  localparam logic [TIME_W-1:0] MAX_VAL = TIME_W'(MODULUS - 1);

  logic [TIME_W-1:0] value_q, value_d;

  assign carry = inc && (value_q == MAX_VAL);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = carry ? '0 : value_q + 1'b1;
    end else if (dec) begin
      value_d = (value_q == '0) ? MAX_VAL : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) value_q <= '0;
    else     value_q <= value_d;
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// 24-hour timekeeper with button set mode; display copy reloads only on vsync
// falling edges so the renderer never sees a mid-frame change.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input logic              clk,
  input logic              rst,
  clock_time_ctrl_if.slave bus
);

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

  // Input history, bit order {vsync, dec, inc, mode}.
  logic [3:0]         in_cur_q, in_prev_q;
  mode_e              mode_q;
  logic               blink_q, sec_tick_q;
  logic [PRESC_W-1:0] presc_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic [TIME_W-1:0]  hour_q, minute_q, second_q;

  logic mode_evt, inc_evt, dec_evt, vsync_fall;
  logic in_run, tick, adj_ok, adj_inc, adj_dec;
  logic [TIME_W-1:0] hour_live, min_live, sec_live;
  logic sec_carry, min_carry, hour_carry;

  assign mode_evt   = in_cur_q[0] & ~in_prev_q[0];
  assign inc_evt    = in_cur_q[1] & ~in_prev_q[1];
  assign dec_evt    = in_cur_q[2] & ~in_prev_q[2];
  assign vsync_fall = ~in_cur_q[3] & in_prev_q[3];

  assign in_run  = (mode_q == MODE_RUN);
  // A mode change takes priority over both the tick and any field adjust.
  assign tick    = in_run && !mode_evt && (presc_q == PRESC_MAX);
  assign adj_ok  = !in_run && !mode_evt && (inc_evt ^ dec_evt);
  assign adj_inc = adj_ok && inc_evt;
  assign adj_dec = adj_ok && dec_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cur_q    <= '0;
      in_prev_q   <= '0;
      mode_q      <= MODE_RUN;
      blink_q     <= 1'b0;
      sec_tick_q  <= 1'b0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
    end else begin
      in_cur_q   <= {bus.vsync, bus.btn_dec, bus.btn_inc, bus.btn_mode};
      in_prev_q  <= in_cur_q;
      sec_tick_q <= tick;
      if (mode_evt) begin
        mode_q      <= next_mode(mode_q);
        presc_q     <= '0;
        blink_cnt_q <= '0;
        blink_q     <= (next_mode(mode_q) != MODE_RUN);
      end else if (in_run) begin
        presc_q     <= tick ? '0 : presc_q + 1'b1;
        blink_cnt_q <= '0;
        blink_q     <= 1'b0;
      end else begin
        presc_q <= '0;
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  mod_counter #(.MODULUS(MIN_SEC_MOD)) u_sec (
    .clk   (clk),
    .clr   (rst),
    .inc   (tick || (adj_inc && mode_q == MODE_SET_SEC)),
    .dec   (adj_dec && mode_q == MODE_SET_SEC),
    .value (sec_live),
    .carry (sec_carry)
  );

  // Carries only propagate on real ticks; set-mode wraps stay within the field.
  mod_counter #(.MODULUS(MIN_SEC_MOD)) u_min (
    .clk   (clk),
    .clr   (rst),
    .inc   ((tick && sec_carry) || (adj_inc && mode_q == MODE_SET_MIN)),
    .dec   (adj_dec && mode_q == MODE_SET_MIN),
    .value (min_live),
    .carry (min_carry)
  );

  mod_counter #(.MODULUS(HOURS_PER_DAY)) u_hour (
    .clk   (clk),
    .clr   (rst),
    .inc   ((tick && sec_carry && min_carry) || (adj_inc && mode_q == MODE_SET_HOUR)),
    .dec   (adj_dec && mode_q == MODE_SET_HOUR),
    .value (hour_live),
    .carry (hour_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
    end else if (vsync_fall) begin
      hour_q   <= hour_live;
      minute_q <= min_live;
      second_q <= sec_live;
    end
  end

  assign bus.hour     = hour_q;
  assign bus.minute   = minute_q;
  assign bus.second   = second_q;
  assign bus.mode     = mode_q;
  assign bus.blink    = blink_q;
  assign bus.sec_tick = sec_tick_q & ~hour_carry;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench: a seconds-of-day reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_clock_time_ctrl;

  localparam int unsigned CLK_HZ       = 10;
  localparam int unsigned BLINK_CYCLES = 4;
  localparam int          DAY          = 86400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .BLINK_CYCLES (BLINK_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] mode;
    logic       blink;
    logic       tick;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_on = 1'b0;

  // Reference state: time as seconds of the day.
  int   t_live, t_disp, m_mode, run_cnt, blink_cnt;
  bit   m_blink, m_tick;
  logic [3:0] hist1, hist2;

  task automatic model_step();
    logic [3:0] cur;
    bit me, ie, de, vf;
    int h, m, s, d;
    obs_t e;
    cur    = {bus.vsync, bus.btn_dec, bus.btn_inc, bus.btn_mode};
    m_tick = 1'b0;
    if (rst) begin
      t_live = 0; t_disp = 0; m_mode = 0; run_cnt = 0; blink_cnt = 0;
      m_blink = 1'b0; hist1 = '0; hist2 = '0;
    end else begin
      me = hist1[0] && !hist2[0];
      ie = hist1[1] && !hist2[1];
      de = hist1[2] && !hist2[2];
      vf = !hist1[3] && hist2[3];
      if (vf) t_disp = t_live;
      if (me) begin
        m_mode    = (m_mode + 1) % 4;
        run_cnt   = 0;
        blink_cnt = 0;
        m_blink   = (m_mode != 0);
      end else if (m_mode == 0) begin
        run_cnt++;
        if (run_cnt == CLK_HZ) begin
          run_cnt = 0;
          m_tick  = 1'b1;
          t_live  = (t_live + 1) % DAY;
        end
      end else begin
        if (ie != de) begin
          h = t_live / 3600; m = (t_live / 60) % 60; s = t_live % 60;
          d = ie ? 1 : -1;
          case (m_mode)
            1:       h = (h + d + 24) % 24;
            2:       m = (m + d + 60) % 60;
            default: s = (s + d + 60) % 60;
          endcase
          t_live = h * 3600 + m * 60 + s;
        end
        blink_cnt++;
        if (blink_cnt == BLINK_CYCLES) begin
          blink_cnt = 0;
          m_blink   = !m_blink;
        end
      end
      hist2 = hist1;
      hist1 = cur;
    end
    e.h     = 6'(t_disp / 3600);
    e.m     = 6'((t_disp / 60) % 60);
    e.s     = 6'(t_disp % 60);
    e.mode  = 2'(m_mode);
    e.blink = m_blink;
    e.tick  = m_tick;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    if (model_on) model_step();
  end

  initial forever begin
    obs_t e, a;
    @(negedge clk);
    if (model_on) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty at %0t: no expected entry for DUT output", $time);
      end else begin
        e = exp_q.pop_front();
        a = {bus.hour, bus.minute, bus.second, bus.mode, bus.blink, bus.sec_tick};
        if (a !== e) begin
          errors++;
          $display("FAIL outputs at %0t: got %0d:%0d:%0d mode=%0d blink=%0b tick=%0b, exp %0d:%0d:%0d mode=%0d blink=%0b tick=%0b",
                   $time, a.h, a.m, a.s, a.mode, a.blink, a.tick,
                   e.h, e.m, e.s, e.mode, e.blink, e.tick);
        end
      end
    end
  end

  // Frame timing: vsync low for one cycle every 50 cycles.
  initial begin
    bus.vsync = 1'b1;
    forever begin
      repeat (49) @(posedge clk);
      #1 bus.vsync = 1'b0;
      @(posedge clk);
      #1 bus.vsync = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      0:       bus.btn_mode = v;
      1:       bus.btn_inc  = v;
      default: bus.btn_dec  = v;
    endcase
  endtask

  task automatic press(input int sel);
    set_btn(sel, 1'b1); cyc(3);
    set_btn(sel, 1'b0); cyc(3);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cyc(1); rst = 1'b0;
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    rst      = 1'b1;
    model_on = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(100);

    // Drive live time to 23:59:58 and let it roll over.
    pulse_rst();
    press(0); press(2);
    press(0); press(2);
    press(0); press(2); press(2);
    press(0);
    cyc(120);

    // Mode stepping, wrap on dec/inc within a field.
    press(0); press(2); press(1);
    press(0); press(2);
    press(0);
    // Simultaneous inc+dec in SET_SEC.
    set_btn(1, 1'b1); set_btn(2, 1'b1); cyc(3);
    set_btn(1, 1'b0); set_btn(2, 1'b0); cyc(3);
    press(0); press(0);
    // mode+inc together in SET_HOUR.
    set_btn(0, 1'b1); set_btn(1, 1'b1); cyc(3);
    set_btn(0, 1'b0); set_btn(1, 1'b0); cyc(3);
    press(0); press(0); press(0);
    // Held inc in SET_HOUR: one event only.
    set_btn(1, 1'b1); cyc(30); set_btn(1, 1'b0); cyc(3);
    press(0); press(0); press(0);
    // Presses in RUN are ignored.
    press(1); press(2);
    cyc(60);

    // Reset mid-count while in SET_MIN.
    press(0); press(0); cyc(5);
    pulse_rst();
    cyc(40);

    // Random button activity with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(7) == 0) set_btn(b, ($urandom_range(1) == 1));
      rst = ($urandom_range(399) == 0);
      cyc(1);
    end
    rst = 1'b0;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
    cyc(60);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
